vscale_fetch: RTL and testbench

VSCALE_FETCH -- requirements
Module: vscale_fetch

---
 rtl/vscale_fetch_if.sv | 34 +++
 rtl/vscale_fetch.sv | 150 +++++++++++++++
 tb/tb_vscale_fetch.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_fetch_if.sv
// rtl/vscale_fetch_if.sv - instruction memory request/response bundle for vscale_fetch
//
// Purpose: groups the fetch unit's instruction memory port.
// Signals:
//   imem_addr      fetch address (fetch -> memory)
//   imem_req       fetch request valid (fetch -> memory)
//   imem_rdata     instruction word for imem_addr (memory -> fetch)
//   imem_wait      memory not ready for the current request (memory -> fetch)
//   imem_badmem_e  access fault for the current request (memory -> fetch)
// Modports: master = fetch unit side, slave = memory side.

interface vscale_fetch_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_wait;
  logic        imem_badmem_e;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_wait,
    input  imem_badmem_e
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_wait,
    output imem_badmem_e
  );
endinterface

// File: rtl/vscale_fetch.sv
// rtl/vscale_fetch.sv - vscale instruction fetch stage with one-word skid buffer
//
// Purpose: holds PC_IF, selects the next PC, issues instruction fetches and
// registers the fetched word (or a bubble) into the DX stage. A single-entry
// skid buffer keeps a returned word while DX is stalled so it is not refetched.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   PC_src_sel           next-PC select (0 +4, 1 branch, 2 jal, 3 reg, 4 stvec, 5-7 +4)
//   branch_target, jal_target, reg_target, stvec   redirect candidates
//   stall_IF, kill_IF, stall_DX                    pipeline control
//   imem                 instruction memory port (vscale_fetch_if.master)
//   PC_IF                address of the instruction in IF
//   inst_DX, PC_DX, badmem_DX   registered instruction, PC and fault flag for DX
//   misaligned_IF        PC_IF is not word aligned

module vscale_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            PC_src_sel,
  input  logic [31:0]           branch_target,
  input  logic [31:0]           jal_target,
  input  logic [31:0]           reg_target,
  input  logic [31:0]           stvec,
  input  logic                  stall_IF,
  input  logic                  kill_IF,
  input  logic                  stall_DX,
  vscale_fetch_if.master        imem,
  output logic [31:0]           PC_IF,
  output logic [31:0]           inst_DX,
  output logic [31:0]           PC_DX,
  output logic                  badmem_DX,
  output logic                  misaligned_IF
);

  localparam logic [2:0] SEL_PLUS_FOUR     = 3'd0;
  localparam logic [2:0] SEL_BRANCH_TARGET = 3'd1;
  localparam logic [2:0] SEL_JAL_TARGET    = 3'd2;
  localparam logic [2:0] SEL_REG_TARGET    = 3'd3;
  localparam logic [2:0] SEL_STVEC         = 3'd4;

  typedef enum logic {
    FETCH,
    HELD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic        redirect;
  logic        capture;
  logic [31:0] buf_inst;
  logic        buf_bad;

  // Next-PC select; any encoding other than the four redirects behaves as +4.
  always_comb begin
    pc_next  = PC_IF + 32'd4;
    redirect = 1'b1;
    case (PC_src_sel)
      SEL_BRANCH_TARGET: pc_next = branch_target;
      SEL_JAL_TARGET:    pc_next = jal_target;
      SEL_REG_TARGET:    pc_next = {reg_target[31:1], 1'b0};
      SEL_STVEC:         pc_next = stvec;
      default: begin
        pc_next  = PC_IF + 32'd4;
        redirect = 1'b0;
      end
    endcase
  end

  assign misaligned_IF  = (PC_IF[1:0] != 2'b00);
  assign imem.imem_addr = PC_IF;

  // A redirect always wins over stall_IF so a taken branch/trap is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_IF <= RESET_PC;
    end else if (!stall_IF || redirect) begin
      PC_IF <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // imem_req is gated by reset so no request escapes while reset is held.
  always_comb begin
    state_next    = state;
    imem.imem_req = 1'b0;
    capture       = 1'b0;
    case (state)
      FETCH: begin
        imem.imem_req = reset && !misaligned_IF;
        if (stall_DX && imem.imem_req && !imem.imem_wait && !redirect) begin
          capture    = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (redirect || !stall_DX) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_inst <= 32'd0;
      buf_bad  <= 1'b0;
    end else if (capture) begin
      buf_inst <= imem.imem_rdata;
      buf_bad  <= imem.imem_badmem_e;
    end
  end

  // DX register: a misaligned PC never reaches memory, so it becomes a
  // faulting bubble unless the slot is being killed anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_DX     <= 32'd0;
      inst_DX   <= NOP_INST;
      badmem_DX <= 1'b0;
    end else if (!stall_DX) begin
      PC_DX <= PC_IF;
      if (kill_IF) begin
        inst_DX   <= NOP_INST;
        badmem_DX <= 1'b0;
      end else if (state == HELD) begin
        inst_DX   <= buf_inst;
        badmem_DX <= buf_bad;
      end else if (misaligned_IF) begin
        inst_DX   <= NOP_INST;
        badmem_DX <= 1'b1;
      end else begin
        inst_DX   <= imem.imem_rdata;
        badmem_DX <= imem.imem_badmem_e;
      end
    end
  end

endmodule

// File: tb/tb_vscale_fetch.sv
// tb/tb_vscale_fetch.sv - self-checking bench for vscale_fetch

module tb_vscale_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [2:0]  PC_src_sel;
  logic [31:0] branch_target, jal_target, reg_target, stvec;
  logic        stall_IF, kill_IF, stall_DX;
  logic [31:0] PC_IF, inst_DX, PC_DX;
  logic        badmem_DX, misaligned_IF;

  vscale_fetch_if imem_bus ();

  vscale_fetch #(
    .RESET_PC(32'h0000_0200),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PC_src_sel   (PC_src_sel),
    .branch_target(branch_target),
    .jal_target   (jal_target),
    .reg_target   (reg_target),
    .stvec        (stvec),
    .stall_IF     (stall_IF),
    .kill_IF      (kill_IF),
    .stall_DX     (stall_DX),
    .imem         (imem_bus.master),
    .PC_IF        (PC_IF),
    .inst_DX      (inst_DX),
    .PC_DX        (PC_DX),
    .badmem_DX    (badmem_DX),
    .misaligned_IF(misaligned_IF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] tgt;
    logic        sif, kif, sdx, wt, bad;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_req;
    logic [31:0] e_pc, e_inst, e_pcdx;
    logic        e_bad;
  } vec_t;

  vec_t tbl[22];

  // Non-selected targets get distinct junk so a wrong mux leg shows up.
  task automatic set_targets(input logic [2:0] sel, input logic [31:0] tgt);
    branch_target = 32'hB000_0010;
    jal_target    = 32'hC000_0020;
    reg_target    = 32'hD000_0031;
    stvec         = 32'hE000_0040;
    case (sel)
      3'd1: branch_target = tgt;
      3'd2: jal_target    = tgt;
      3'd3: reg_target    = tgt;
      3'd4: stvec         = tgt;
      default: ;
    endcase
  endtask

  task automatic drive(input logic [2:0] sel, input logic sif, kif, sdx, wt, bad,
                       input logic [31:0] rdata);
    PC_src_sel             = sel;
    stall_IF               = sif;
    kill_IF                = kif;
    stall_DX               = sdx;
    imem_bus.imem_wait     = wt;
    imem_bus.imem_badmem_e = bad;
    imem_bus.imem_rdata    = rdata;
  endtask

  // Reference model state: the skid buffer is a queue of {fault, word}.
  logic [31:0] m_pc, m_pcdx, m_inst, m_nx;
  logic        m_bad, m_req, m_redir;
  logic [32:0] skid_q[$];

  initial begin
    reset = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_targets(3'd0, 32'h0);

    // Reset state, held across edges.
    repeat (2) @(negedge clk);
    check("rst_pc_if",   PC_IF, 32'h200);
    check("rst_pc_dx",   PC_DX, 32'h0);
    check("rst_inst_dx", inst_DX, NOP);
    check("rst_bad_dx",  {31'd0, badmem_DX}, 32'd0);
    check("rst_req",     {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_addr",    imem_bus.imem_addr, 32'h200);

    //          sel  tgt           sif  kif  sdx  wt   bad  rdata          e_addr        e_req e_pc          e_inst        e_pcdx        e_bad
    tbl[0]  = '{3'd0, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h1111_0001, 32'h200,      1'b1, 32'h204,      32'h1111_0001,32'h200,      1'b0};
    tbl[1]  = '{3'd0, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h1111_0002, 32'h204,      1'b1, 32'h208,      32'h1111_0002,32'h204,      1'b0};
    tbl[2]  = '{3'd3, 32'h301,      1'b0,1'b1,1'b0,1'b0,1'b0,32'h1111_0003, 32'h208,      1'b1, 32'h300,      NOP,          32'h208,      1'b0};
    tbl[3]  = '{3'd2, 32'h210,      1'b0,1'b1,1'b0,1'b0,1'b0,32'h1111_0004, 32'h300,      1'b1, 32'h210,      NOP,          32'h300,      1'b0};
    tbl[4]  = '{3'd0, 32'h0,        1'b1,1'b1,1'b0,1'b1,1'b0,32'hEEEE_EEEE, 32'h210,      1'b1, 32'h210,      NOP,          32'h210,      1'b0};
    tbl[5]  = '{3'd0, 32'h0,        1'b1,1'b1,1'b0,1'b1,1'b0,32'hEEEE_EEEE, 32'h210,      1'b1, 32'h210,      NOP,          32'h210,      1'b0};
    tbl[6]  = '{3'd0, 32'h0,        1'b1,1'b1,1'b0,1'b1,1'b0,32'hEEEE_EEEE, 32'h210,      1'b1, 32'h210,      NOP,          32'h210,      1'b0};
    tbl[7]  = '{3'd0, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h2222_0210, 32'h210,      1'b1, 32'h214,      32'h2222_0210,32'h210,      1'b0};
    tbl[8]  = '{3'd0, 32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,32'h0010_0093, 32'h214,      1'b1, 32'h214,      32'h2222_0210,32'h210,      1'b0};
    tbl[9]  = '{3'd0, 32'h0,        1'b1,1'b0,1'b1,1'b1,1'b0,32'h5555_5555, 32'h214,      1'b0, 32'h214,      32'h2222_0210,32'h210,      1'b0};
    tbl[10] = '{3'd0, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h6666_6666, 32'h214,      1'b0, 32'h218,      32'h0010_0093,32'h214,      1'b0};
    tbl[11] = '{3'd0, 32'h0,        1'b1,1'b0,1'b1,1'b0,1'b1,32'h3333_0218, 32'h218,      1'b1, 32'h218,      32'h0010_0093,32'h214,      1'b0};
    tbl[12] = '{3'd4, 32'h100,      1'b1,1'b0,1'b1,1'b0,1'b0,32'h7777_0000, 32'h218,      1'b0, 32'h100,      32'h0010_0093,32'h214,      1'b0};
    tbl[13] = '{3'd0, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h4444_0100, 32'h100,      1'b1, 32'h104,      32'h4444_0100,32'h100,      1'b0};
    tbl[14] = '{3'd2, 32'hFFFF_FFFC,1'b0,1'b1,1'b0,1'b0,1'b0,32'h1111_0005, 32'h104,      1'b1, 32'hFFFF_FFFC,NOP,          32'h104,      1'b0};
    tbl[15] = '{3'd0, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h7777_FFFC, 32'hFFFF_FFFC,1'b1, 32'h0,        32'h7777_FFFC,32'hFFFF_FFFC,1'b0};
    tbl[16] = '{3'd1, 32'h402,      1'b0,1'b0,1'b0,1'b0,1'b0,32'h8888_0000, 32'h0,        1'b1, 32'h402,      32'h8888_0000,32'h0,        1'b0};
    tbl[17] = '{3'd0, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h9999_9999, 32'h402,      1'b0, 32'h406,      NOP,          32'h402,      1'b1};
    tbl[18] = '{3'd3, 32'h505,      1'b0,1'b0,1'b0,1'b0,1'b0,32'h9999_9998, 32'h406,      1'b0, 32'h504,      NOP,          32'h406,      1'b1};
    tbl[19] = '{3'd0, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b1,32'hABCD_0504, 32'h504,      1'b1, 32'h508,      32'hABCD_0504,32'h504,      1'b1};
    tbl[20] = '{3'd5, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h1234_5678, 32'h508,      1'b1, 32'h50C,      32'h1234_5678,32'h508,      1'b0};
    tbl[21] = '{3'd7, 32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0,32'h1234_0000, 32'h50C,      1'b1, 32'h50C,      NOP,          32'h50C,      1'b0};

    reset = 1'b1;
    for (int i = 0; i < 22; i++) begin
      set_targets(tbl[i].sel, tbl[i].tgt);
      drive(tbl[i].sel, tbl[i].sif, tbl[i].kif, tbl[i].sdx, tbl[i].wt, tbl[i].bad, tbl[i].rdata);
      #1;
      check($sformatf("row%0d_addr", i), imem_bus.imem_addr, tbl[i].e_addr);
      check($sformatf("row%0d_req", i), {31'd0, imem_bus.imem_req}, {31'd0, tbl[i].e_req});
      check($sformatf("row%0d_misal", i), {31'd0, misaligned_IF},
            {31'd0, tbl[i].e_addr[1:0] != 2'b00});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d_pc_if", i), PC_IF, tbl[i].e_pc);
      check($sformatf("row%0d_inst_dx", i), inst_DX, tbl[i].e_inst);
      check($sformatf("row%0d_pc_dx", i), PC_DX, tbl[i].e_pcdx);
      check($sformatf("row%0d_bad_dx", i), {31'd0, badmem_DX}, {31'd0, tbl[i].e_bad});
    end

    // Reset asserted while a word sits in the skid buffer (PC_IF = 0x50C).
    set_targets(3'd0, 32'h0);
    drive(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001);
    @(posedge clk);
    @(negedge clk);
    check("held_req", {31'd0, imem_bus.imem_req}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_pc_if", PC_IF, 32'h200);
    check("async_rst_inst",  inst_DX, NOP);
    check("async_rst_pc_dx", PC_DX, 32'h0);
    check("async_rst_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1357_0200);
    #1;
    check("post_rst_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("post_rst_addr", imem_bus.imem_addr, 32'h200);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_inst",  inst_DX, 32'h1357_0200);
    check("post_rst_pc_dx", PC_DX, 32'h200);

    // Reset asserted in the middle of a memory wait.
    drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_0000);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2468_0200);
    #1;
    check("wait_rst_addr", imem_bus.imem_addr, 32'h200);
    check("wait_rst_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("wait_rst_inst", inst_DX, 32'h2468_0200);

    // Randomised run against the behavioural model, starting from reset.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_pc = 32'h200; m_pcdx = 32'h0; m_inst = NOP; m_bad = 1'b0;
    skid_q.delete();
    for (int c = 0; c < 600; c++) begin
      PC_src_sel    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      branch_target = $urandom;
      jal_target    = $urandom;
      reg_target    = $urandom;
      stvec         = $urandom;
      if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jal_target[1:0]    = 2'b00;
      if ($urandom_range(0, 3) != 0) reg_target[1:0]    = 2'b00;
      if ($urandom_range(0, 3) != 0) stvec[1:0]         = 2'b00;
      stall_IF               = ($urandom_range(0, 3) == 0);
      kill_IF                = ($urandom_range(0, 4) == 0);
      stall_DX               = ($urandom_range(0, 2) == 0);
      imem_bus.imem_wait     = ($urandom_range(0, 3) == 0);
      imem_bus.imem_badmem_e = ($urandom_range(0, 9) == 0);
      imem_bus.imem_rdata    = $urandom;
      #1;
      m_req = (skid_q.size() == 0) && (m_pc[1:0] == 2'b00);
      check("rnd_addr",  imem_bus.imem_addr, m_pc);
      check("rnd_req",   {31'd0, imem_bus.imem_req}, {31'd0, m_req});
      check("rnd_misal", {31'd0, misaligned_IF}, {31'd0, m_pc[1:0] != 2'b00});

      m_redir = (PC_src_sel >= 3'd1) && (PC_src_sel <= 3'd4);
      case (PC_src_sel)
        3'd1:    m_nx = branch_target;
        3'd2:    m_nx = jal_target;
        3'd3:    m_nx = reg_target & 32'hFFFF_FFFE;
        3'd4:    m_nx = stvec;
        default: m_nx = m_pc + 32'd4;
      endcase
      if (!stall_DX) begin
        m_pcdx = m_pc;
        if (kill_IF) begin
          m_inst = NOP; m_bad = 1'b0;
        end else if (skid_q.size() != 0) begin
          {m_bad, m_inst} = skid_q[0];
        end else if (m_pc[1:0] != 2'b00) begin
          m_inst = NOP; m_bad = 1'b1;
        end else begin
          m_inst = imem_bus.imem_rdata; m_bad = imem_bus.imem_badmem_e;
        end
      end
      if (skid_q.size() != 0) begin
        if (m_redir || !stall_DX) skid_q.delete();
      end else if (stall_DX && m_req && !imem_bus.imem_wait && !m_redir) begin
        skid_q.push_back({imem_bus.imem_badmem_e, imem_bus.imem_rdata});
      end
      if (!stall_IF || m_redir) m_pc = m_nx;

      @(posedge clk);
      @(negedge clk);
      check("rnd_pc_if",   PC_IF, m_pc);
      check("rnd_inst_dx", inst_DX, m_inst);
      check("rnd_pc_dx",   PC_DX, m_pcdx);
      check("rnd_bad_dx",  {31'd0, badmem_DX}, {31'd0, m_bad});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
